// File: rtl/can_xl_form_checker_if.sv
// Bus bundle between the CAN XL receive path and the form checker.
// master drives bit stream/control, slave (the checker) returns error reporting.
interface can_xl_form_checker_if #(
    parameter int DLEN_W = 14,
    parameter int BCNT_W = 15,
    parameter int CNT_W  = 8
);
    logic              bit_strobe;
    logic              serial_in;
    logic              sof;
    logic              dl_valid;
    logic [DLEN_W-1:0] rcvd_data_len;
    logic              abort;
    logic              err_clr;
    logic              frm_err;
    logic              frm_err_sticky;
    logic [1:0]        frm_err_field;
    logic [BCNT_W-1:0] frm_err_pos;
    logic [CNT_W-1:0]  frm_err_cnt;
    logic              tail_done;
    logic              busy;

    modport master (
        output bit_strobe, serial_in, sof, dl_valid, rcvd_data_len, abort, err_clr,
        input  frm_err, frm_err_sticky, frm_err_field, frm_err_pos, frm_err_cnt,
               tail_done, busy
    );

    modport slave (
        input  bit_strobe, serial_in, sof, dl_valid, rcvd_data_len, abort, err_clr,
        output frm_err, frm_err_sticky, frm_err_field, frm_err_pos, frm_err_cnt,
               tail_done, busy
    );
endinterface

// File: rtl/can_xl_form_checker.sv
// CAN XL form-error detector: tracks bit index from SOF and checks the
// CRC delimiter, ACK delimiter and EOF bits for recessive level.
module can_xl_form_checker #(
    parameter int DLEN_W           = 14,
    parameter int BCNT_W           = 15,
    parameter int HDR_BITS         = 97,
    parameter int CRC_BITS         = 32,
    parameter int GAP_BITS         = 8,
    parameter int ACK_SLOT_BITS    = 1,
    parameter int EOF_BITS         = 7,
    parameter int LAST_EOF_LENIENT = 1,
    parameter int CNT_W            = 8
) (
    input  logic                   clk,
    input  logic                   g_rst,
    can_xl_form_checker_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_COUNT, ST_CRC_DEL, ST_ACK_SLOT, ST_ACK_DEL, ST_EOF, ST_HALT
    } state_t;

    localparam int SUB_MAX = (ACK_SLOT_BITS > EOF_BITS) ? ACK_SLOT_BITS : EOF_BITS;
    localparam int SUB_W   = (SUB_MAX < 2) ? 1 : $clog2(SUB_MAX);
    localparam logic [BCNT_W:0] FIXED_BITS = (BCNT_W+1)'(HDR_BITS + CRC_BITS + GAP_BITS);

    state_t              state_reg;
    logic [BCNT_W-1:0]   bcnt_reg;
    logic [DLEN_W-1:0]   len_reg;
    logic                len_ok_reg;
    logic [SUB_W-1:0]    sub_reg;
    logic                frm_err_reg;
    logic                sticky_reg;
    logic [1:0]          field_reg;
    logic [BCNT_W-1:0]   pos_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                tail_done_reg;
    logic                busy_reg;

    logic [BCNT_W-1:0]   bcnt_inc;
    logic [BCNT_W:0]     tail_start;
    logic [BCNT_W:0]     next_plus;
    logic                tail_hit;
    logic                eof_last;
    logic                ack_last;
    logic                strobe_ok;
    logic                err_hit;
    logic [1:0]          err_code;

    assign bcnt_inc   = (&bcnt_reg) ? bcnt_reg : bcnt_reg + BCNT_W'(1);
    assign tail_start = FIXED_BITS + (BCNT_W+1)'(len_reg);
    assign next_plus  = {1'b0, bcnt_inc} + (BCNT_W+1)'(1);
    // The transition fires on the bit before T so the delimiter itself is sampled in CRC_DEL.
    // A tail start beyond the counter range can never match.
    assign tail_hit   = len_ok_reg && !tail_start[BCNT_W] && (next_plus == tail_start);
    assign eof_last   = (sub_reg == SUB_W'(EOF_BITS - 1));
    assign ack_last   = (sub_reg == SUB_W'(ACK_SLOT_BITS - 1));
    assign strobe_ok  = bus.bit_strobe && !bus.abort && !bus.sof;

    always_comb begin
        err_hit  = 1'b0;
        err_code = 2'd0;
        if (strobe_ok && !bus.serial_in) begin
            case (state_reg)
                ST_CRC_DEL: begin err_hit = 1'b1; err_code = 2'd1; end
                ST_ACK_DEL: begin err_hit = 1'b1; err_code = 2'd2; end
                ST_EOF: begin
                    if (!(LAST_EOF_LENIENT != 0 && eof_last)) begin
                        err_hit  = 1'b1;
                        err_code = 2'd3;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            state_reg     <= ST_IDLE;
            bcnt_reg      <= '0;
            len_reg       <= '0;
            len_ok_reg    <= 1'b0;
            sub_reg       <= '0;
            tail_done_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            tail_done_reg <= 1'b0;
            if (bus.abort) begin
                state_reg  <= ST_IDLE;
                len_ok_reg <= 1'b0;
                busy_reg   <= 1'b0;
            end else if (bus.sof) begin
                state_reg  <= ST_COUNT;
                bcnt_reg   <= '0;
                len_ok_reg <= 1'b0;
                sub_reg    <= '0;
                busy_reg   <= 1'b1;
            end else begin
                if (bus.dl_valid && state_reg == ST_COUNT) begin
                    len_reg    <= bus.rcvd_data_len;
                    len_ok_reg <= 1'b1;
                end
                if (bus.bit_strobe && state_reg != ST_IDLE && state_reg != ST_HALT) begin
                    bcnt_reg <= bcnt_inc;
                    if (err_hit) begin
                        state_reg <= ST_HALT;
                    end else begin
                        case (state_reg)
                            ST_COUNT: if (tail_hit) state_reg <= ST_CRC_DEL;
                            ST_CRC_DEL: begin
                                state_reg <= ST_ACK_SLOT;
                                sub_reg   <= '0;
                            end
                            ST_ACK_SLOT: begin
                                if (ack_last) begin
                                    state_reg <= ST_ACK_DEL;
                                    sub_reg   <= '0;
                                end else begin
                                    sub_reg <= sub_reg + SUB_W'(1);
                                end
                            end
                            ST_ACK_DEL: state_reg <= ST_EOF;
                            ST_EOF: begin
                                if (eof_last) begin
                                    state_reg     <= ST_IDLE;
                                    busy_reg      <= 1'b0;
                                    tail_done_reg <= 1'b1;
                                end else begin
                                    sub_reg <= sub_reg + SUB_W'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Error reporting; a new error outranks a same-cycle clear so the count restarts at 1.
    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            frm_err_reg <= 1'b0;
            sticky_reg  <= 1'b0;
            field_reg   <= 2'd0;
            pos_reg     <= '0;
            cnt_reg     <= '0;
        end else begin
            frm_err_reg <= err_hit;
            if (err_hit) begin
                sticky_reg <= 1'b1;
                field_reg  <= err_code;
                pos_reg    <= bcnt_inc;
                if (bus.err_clr)
                    cnt_reg <= CNT_W'(1);
                else if (!(&cnt_reg))
                    cnt_reg <= cnt_reg + CNT_W'(1);
            end else if (bus.err_clr) begin
                sticky_reg <= 1'b0;
                cnt_reg    <= '0;
            end
        end
    end

    assign bus.frm_err        = frm_err_reg;
    assign bus.frm_err_sticky = sticky_reg;
    assign bus.frm_err_field  = field_reg;
    assign bus.frm_err_pos    = pos_reg;
    assign bus.frm_err_cnt    = cnt_reg;
    assign bus.tail_done      = tail_done_reg;
    assign bus.busy           = busy_reg;
endmodule

// File: tb/tb_can_xl_form_checker.sv
// Scoreboard bench: three checker instances (lenient, strict, short header)
// share one bit stream; a frame-level model predicts each one's pulses.
module tb_can_xl_form_checker;
    logic clk = 1'b0;
    logic g_rst = 1'b1;
    always #5 clk = ~clk;

    logic        bit_strobe = 1'b0;
    logic        serial_in = 1'b1;
    logic        sof = 1'b0;
    logic        dl_valid = 1'b0;
    logic [13:0] rcvd_data_len = '0;
    logic        abort = 1'b0;
    logic        err_clr = 1'b0;

    can_xl_form_checker_if #(.DLEN_W(14), .BCNT_W(15), .CNT_W(8)) ifa ();
    can_xl_form_checker_if #(.DLEN_W(14), .BCNT_W(15), .CNT_W(8)) ifb ();
    can_xl_form_checker_if #(.DLEN_W(14), .BCNT_W(15), .CNT_W(8)) ifc ();

    can_xl_form_checker #(.LAST_EOF_LENIENT(1)) dut_a (.clk(clk), .g_rst(g_rst), .bus(ifa));
    can_xl_form_checker #(.LAST_EOF_LENIENT(0)) dut_b (.clk(clk), .g_rst(g_rst), .bus(ifb));
    can_xl_form_checker #(.HDR_BITS(4), .CRC_BITS(2), .GAP_BITS(1), .LAST_EOF_LENIENT(1))
        dut_c (.clk(clk), .g_rst(g_rst), .bus(ifc));

    assign ifa.bit_strobe = bit_strobe;  assign ifb.bit_strobe = bit_strobe;  assign ifc.bit_strobe = bit_strobe;
    assign ifa.serial_in  = serial_in;   assign ifb.serial_in  = serial_in;   assign ifc.serial_in  = serial_in;
    assign ifa.sof        = sof;         assign ifb.sof        = sof;         assign ifc.sof        = sof;
    assign ifa.dl_valid   = dl_valid;    assign ifb.dl_valid   = dl_valid;    assign ifc.dl_valid   = dl_valid;
    assign ifa.rcvd_data_len = rcvd_data_len;
    assign ifb.rcvd_data_len = rcvd_data_len;
    assign ifc.rcvd_data_len = rcvd_data_len;
    assign ifa.abort      = abort;       assign ifb.abort      = abort;       assign ifc.abort      = abort;
    assign ifa.err_clr    = err_clr;     assign ifb.err_clr    = err_clr;     assign ifc.err_clr    = err_clr;

    logic        o_err [3];
    logic        o_tail [3];
    logic        o_sticky [3];
    logic        o_busy [3];
    logic [1:0]  o_field [3];
    logic [14:0] o_pos [3];
    logic [7:0]  o_cnt [3];

    assign o_err[0] = ifa.frm_err;  assign o_tail[0] = ifa.tail_done;  assign o_sticky[0] = ifa.frm_err_sticky;
    assign o_err[1] = ifb.frm_err;  assign o_tail[1] = ifb.tail_done;  assign o_sticky[1] = ifb.frm_err_sticky;
    assign o_err[2] = ifc.frm_err;  assign o_tail[2] = ifc.tail_done;  assign o_sticky[2] = ifc.frm_err_sticky;
    assign o_busy[0] = ifa.busy;    assign o_field[0] = ifa.frm_err_field; assign o_pos[0] = ifa.frm_err_pos;
    assign o_busy[1] = ifb.busy;    assign o_field[1] = ifb.frm_err_field; assign o_pos[1] = ifb.frm_err_pos;
    assign o_busy[2] = ifc.busy;    assign o_field[2] = ifc.frm_err_field; assign o_pos[2] = ifc.frm_err_pos;
    assign o_cnt[0] = ifa.frm_err_cnt;
    assign o_cnt[1] = ifb.frm_err_cnt;
    assign o_cnt[2] = ifc.frm_err_cnt;

    // Per-instance frame geometry for the reference model.
    int p_hdr [3] = '{97, 97, 4};
    int p_crc [3] = '{32, 32, 2};
    int p_gap [3] = '{8, 8, 1};
    int p_len [3] = '{1, 0, 1};
    localparam int ACK_N = 1;
    localparam int EOF_N = 7;

    typedef struct {
        int kind;   // 1 = form error, 2 = tail_done
        int field;
        int pos;
        int cnt;
    } exp_t;

    exp_t exp_q [3][$];
    int   cnt_m [3];
    int   sticky_m [3];
    int   checks = 0;
    int   errors = 0;

    logic frame_bits [0:511];
    int   f_len, f_len2, f_dl, f_nbits, f_abort_at, f_clr_at;

    task automatic check(input string name, input int d, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d, expected %0d", name, d, act, req);
        end
    endtask

    // Monitor: every output pulse must match the head of that instance's queue.
    initial begin
        exp_t e;
        int   kind;
        bit   ok;
        forever begin
            @(negedge clk);
            if (!g_rst) begin
                for (int d = 0; d < 3; d++) begin
                    if (o_err[d] || o_tail[d]) begin
                        checks++;
                        kind = o_err[d] ? 1 : 2;
                        if (exp_q[d].size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_pulse dut%0d: got kind=%0d field=%0d pos=%0d, expected no pulse",
                                     d, kind, o_field[d], o_pos[d]);
                        end else begin
                            e = exp_q[d].pop_front();
                            ok = (kind == e.kind) &&
                                 (kind == 2 || (o_field[d] == 2'(e.field) && o_pos[d] == 15'(e.pos) &&
                                                o_cnt[d] == 8'(e.cnt) && o_sticky[d] == 1'b1));
                            if (!ok) begin
                                errors++;
                                $display("FAIL pulse dut%0d: got kind=%0d field=%0d pos=%0d cnt=%0d sticky=%0d, expected kind=%0d field=%0d pos=%0d cnt=%0d sticky=1",
                                         d, kind, o_field[d], o_pos[d], o_cnt[d], o_sticky[d],
                                         e.kind, e.field, e.pos, e.cnt);
                            end
                        end
                    end
                end
            end
        end
    end

    // Frame outcome from the field layout: first dominant checked bit, else tail completion.
    function automatic void model(input int d, output int kind, output int field, output int pos);
        int len, t, lim, last, fld;
        kind = 0; field = 0; pos = 0;
        if (f_dl == 0) return;
        len  = (f_len2 >= 0) ? f_len2 : f_len;
        t    = p_hdr[d] + len + p_crc[d] + p_gap[d];
        lim  = (f_abort_at >= 0) ? f_abort_at : f_nbits;
        last = t + 1 + ACK_N + EOF_N;
        for (int p = t; p <= last; p++) begin
            if (p >= lim) return;
            if (p == t) fld = 1;
            else if (p == t + 1 + ACK_N) fld = 2;
            else if (p > t + 1 + ACK_N && !(p == last && p_len[d] != 0)) fld = 3;
            else fld = 0;
            if (fld != 0 && frame_bits[p] == 1'b0) begin
                kind = 1; field = fld; pos = p;
                return;
            end
        end
        kind = 2; pos = last;
    endfunction

    task automatic strobe(input logic b, input logic s, input logic a, input logic c);
        bit_strobe = 1'b1; serial_in = b; sof = s; abort = a; err_clr = c;
        @(posedge clk); #1;
        bit_strobe = 1'b0; serial_in = 1'b1; sof = 1'b0; abort = 1'b0; err_clr = 1'b0;
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_dl(input int v);
        dl_valid = 1'b1; rcvd_data_len = 14'(v);
        @(posedge clk); #1;
        dl_valid = 1'b0;
    endtask

    task automatic setup(input int len, input int nbits);
        f_len = len; f_len2 = -1; f_dl = 1; f_nbits = nbits; f_abort_at = -1; f_clr_at = -1;
        for (int i = 0; i < 512; i++) frame_bits[i] = 1'b1;
    endtask

    task automatic run_frame();
        int  kind, field, pos;
        bit  clr_eff;
        int  busy_m [3];
        clr_eff = (f_clr_at >= 0) && (f_clr_at < f_nbits) && (f_abort_at < 0 || f_clr_at <= f_abort_at);
        for (int d = 0; d < 3; d++) begin
            model(d, kind, field, pos);
            if (kind == 1) begin
                if (clr_eff && f_clr_at <= pos) begin cnt_m[d] = 0; sticky_m[d] = 0; end
                cnt_m[d] = (cnt_m[d] == 255) ? 255 : cnt_m[d] + 1;
                sticky_m[d] = 1;
                exp_q[d].push_back('{1, field, pos, cnt_m[d]});
                if (clr_eff && f_clr_at > pos) begin cnt_m[d] = 0; sticky_m[d] = 0; end
            end else begin
                if (clr_eff) begin cnt_m[d] = 0; sticky_m[d] = 0; end
                if (kind == 2) exp_q[d].push_back('{2, 0, pos, 0});
            end
            busy_m[d] = (f_abort_at >= 0 || kind == 2) ? 0 : 1;
        end
        for (int i = 0; i < f_nbits; i++) begin
            strobe(frame_bits[i], i == 0, i == f_abort_at, i == f_clr_at);
            if (i == f_abort_at) break;
            if (i == 1 && f_dl != 0) pulse_dl(f_len);
            if (i == 2 && f_len2 >= 0) pulse_dl(f_len2);
        end
        repeat (2) begin @(posedge clk); #1; end
        for (int d = 0; d < 3; d++) begin
            check("busy_end", d, o_busy[d], busy_m[d]);
            check("cnt_end", d, o_cnt[d], cnt_m[d]);
            check("sticky_end", d, o_sticky[d], sticky_m[d]);
        end
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        for (int d = 0; d < 3; d++) begin
            cnt_m[d] = 0; sticky_m[d] = 0;
            check("clr_cnt", d, o_cnt[d], 0);
            check("clr_sticky", d, o_sticky[d], 0);
        end
    endtask

    initial begin
        int len;
        for (int d = 0; d < 3; d++) begin cnt_m[d] = 0; sticky_m[d] = 0; end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_frm_err", d, o_err[d], 0);
            check("rst_sticky", d, o_sticky[d], 0);
            check("rst_field", d, o_field[d], 0);
            check("rst_pos", d, o_pos[d], 0);
            check("rst_cnt", d, o_cnt[d], 0);
            check("rst_tail", d, o_tail[d], 0);
            check("rst_busy", d, o_busy[d], 0);
        end
        g_rst = 1'b0;
        @(posedge clk); #1;

        // Clean frame, len 16 (T = 153 on the default geometry).
        setup(16, 163);
        strobe(1'b1, 1'b1, 1'b0, 1'b0);
        check("busy_after_sof", 0, o_busy[0], 1);
        f_nbits = 163;
        run_frame();
        // Dominant CRC delimiter, extra strobes afterwards must be ignored.
        setup(16, 175); frame_bits[153] = 1'b0; run_frame();
        // Dominant EOF bit 158.
        setup(16, 163); frame_bits[158] = 1'b0; run_frame();
        // Dominant last EOF bit: lenient vs strict instance.
        setup(16, 163); frame_bits[162] = 1'b0; run_frame();
        // ACK slot dominant is fine, ACK delimiter dominant is not.
        setup(16, 163); frame_bits[154] = 1'b0; frame_bits[155] = 1'b0; run_frame();
        // Abort at 154.
        setup(16, 163); f_abort_at = 154; frame_bits[158] = 1'b0; run_frame();
        // len 0, dominant at 137 with a coincident clear.
        setup(0, 140); frame_bits[137] = 1'b0; f_clr_at = 137; run_frame();
        // No length ever latched.
        setup(0, 400); f_dl = 0;
        for (int i = 0; i < 400; i++) frame_bits[i] = ($urandom_range(0, 3) != 0);
        run_frame();

        // Randomized frames.
        for (int n = 0; n < 30; n++) begin
            len = $urandom_range(0, 40);
            setup(len, 137 + len + $urandom_range(0, 14));
            if ($urandom_range(0, 3) == 0) f_len2 = $urandom_range(0, 40);
            if (f_len2 >= 0) f_nbits = 137 + f_len2 + $urandom_range(0, 14);
            for (int i = 1; i < f_nbits; i++) frame_bits[i] = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 5) == 0) f_abort_at = $urandom_range(1, f_nbits - 1);
            if ($urandom_range(0, 7) == 0) f_clr_at = $urandom_range(1, f_nbits - 1);
            run_frame();
            if ($urandom_range(0, 9) == 0) clear_errors();
        end

        // Counter saturation on the short-header instance (T = 7 with len 0).
        clear_errors();
        for (int n = 0; n < 256; n++) begin
            setup(0, 8);
            frame_bits[7] = 1'b0;
            run_frame();
        end
        check("cnt_saturated", 2, o_cnt[2], 255);

        repeat (5) begin @(posedge clk); #1; end
        for (int d = 0; d < 3; d++) check("queue_drained", d, exp_q[d].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
